// File: rtl/packet_tx_encoder.sv
`default_nettype none
// ============================================================================
// Module   : packet_tx_encoder
// Brief    : Encodes 8-bit items into 20-bit packets and distributes them in
//            strict alternation onto two buffered output lanes.
// Revision : 1.0 - initial release
// ============================================================================
module packet_tx_encoder #(
    parameter int LANE_DEPTH = 4,
    parameter int CW         = $clog2(LANE_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    output logic          lane1_valid,
    input  logic          lane1_ready,
    output logic [19:0]   lane1_data,
    output logic [CW-1:0] lane1_count,
    output logic          lane2_valid,
    input  logic          lane2_ready,
    output logic [19:0]   lane2_data,
    output logic [CW-1:0] lane2_count,
    output logic          next_lane,
    output logic [3:0]    seq
);

    localparam int c_pw = $clog2(LANE_DEPTH);

    logic                 r_next_lane;
    logic [3:0]           r_seq;
    logic                 w_accept;
    logic [19:0]          w_packet;
    logic [1:0]           w_full;
    logic [1:0]           w_lane_ready;
    logic [1:0]           w_lane_valid;
    logic [1:0][19:0]     w_lane_data;
    logic [1:0][CW-1:0]   w_lane_count;

    // Ready depends only on registered state, never on in_valid.
    assign in_ready     = ~w_full[r_next_lane];
    assign w_accept     = in_valid && in_ready;
    assign w_packet     = {r_seq, ~in_data, in_data ^ {4'h0, r_seq}};
    assign w_lane_ready = {lane2_ready, lane1_ready};

    assign next_lane    = r_next_lane;
    assign seq          = r_seq;
    assign lane1_valid  = w_lane_valid[0];
    assign lane1_data   = w_lane_data[0];
    assign lane1_count  = w_lane_count[0];
    assign lane2_valid  = w_lane_valid[1];
    assign lane2_data   = w_lane_data[1];
    assign lane2_count  = w_lane_count[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_next_lane <= 1'b0;
            r_seq       <= 4'h0;
        end else if (w_accept) begin
            r_next_lane <= ~r_next_lane;
            r_seq       <= r_seq + 4'd1;
        end
    end

    generate
        for (genvar g = 0; g < 2; g++) begin : g_lane
            localparam logic c_lane_id = (g == 1);

            logic [19:0]     r_mem [LANE_DEPTH];
            logic [c_pw-1:0] r_wr_ptr;
            logic [c_pw-1:0] r_rd_ptr;
            logic [CW-1:0]   r_count;
            logic            w_push;
            logic            w_pop;
            logic            w_valid;

            assign w_valid         = (r_count != '0);
            assign w_push          = w_accept && (r_next_lane == c_lane_id);
            assign w_pop           = w_valid && w_lane_ready[g];
            assign w_full[g]       = (r_count == CW'(LANE_DEPTH));
            assign w_lane_valid[g] = w_valid;
            assign w_lane_data[g]  = w_valid ? r_mem[r_rd_ptr] : 20'h00000;
            assign w_lane_count[g] = r_count;

            // Storage is intentionally left unreset; the head is masked by valid.
            always_ff @(posedge clk) begin
                if (w_push) begin
                    r_mem[r_wr_ptr] <= w_packet;
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_wr_ptr <= '0;
                    r_rd_ptr <= '0;
                    r_count  <= '0;
                end else begin
                    if (w_push) begin
                        r_wr_ptr <= r_wr_ptr + c_pw'(1);
                    end
                    if (w_pop) begin
                        r_rd_ptr <= r_rd_ptr + c_pw'(1);
                    end
                    case ({w_push, w_pop})
                        2'b10:   r_count <= r_count + CW'(1);
                        2'b01:   r_count <= r_count - CW'(1);
                        default: r_count <= r_count;
                    endcase
                end
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_packet_tx_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_packet_tx_encoder
// Brief    : Scoreboard bench for packet_tx_encoder (lane queues + item queues).
// Revision : 1.0 - initial release
// ============================================================================
module tb_packet_tx_encoder;

    localparam int c_depth = 4;
    localparam int c_cw    = $clog2(c_depth + 1);

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic [7:0]      in_data;
    logic            in_ready;
    logic            lane1_valid, lane2_valid;
    logic            lane1_ready, lane2_ready;
    logic [19:0]     lane1_data, lane2_data;
    logic [c_cw-1:0] lane1_count, lane2_count;
    logic            next_lane;
    logic [3:0]      seq;

    int n_tests = 0;
    int n_fail  = 0;

    logic [19:0] exp_q1[$], exp_q2[$];
    logic [7:0]  itm_q1[$], itm_q2[$];
    logic        m_next;
    logic [3:0]  m_seq;

    packet_tx_encoder #(.LANE_DEPTH(c_depth)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .lane1_valid (lane1_valid),
        .lane1_ready (lane1_ready),
        .lane1_data  (lane1_data),
        .lane1_count (lane1_count),
        .lane2_valid (lane2_valid),
        .lane2_ready (lane2_ready),
        .lane2_data  (lane2_data),
        .lane2_count (lane2_count),
        .next_lane   (next_lane),
        .seq         (seq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic m_ready();
        int sz;
        sz = m_next ? exp_q2.size() : exp_q1.size();
        return sz != c_depth;
    endfunction

    function automatic logic [7:0] recover(input logic [19:0] p);
        logic [15:0] t;
        t = p[15:0] ^ {12'h000, p[19:16]};
        return t[7:0];
    endfunction

    // One clock: compare all outputs against the model mid-cycle, then advance
    // the model with the handshakes seen at the rising edge.
    task automatic tick();
        logic acc, pop1, pop2;
        logic [19:0] pkt;
        @(negedge clk);
        check("in_ready", in_ready, m_ready());
        check("next_lane", next_lane, m_next);
        check("seq", seq, m_seq);
        check("l1_valid", lane1_valid, exp_q1.size() != 0);
        check("l1_data", lane1_data, exp_q1.size() != 0 ? exp_q1[0] : 20'h0);
        check("l1_count", lane1_count, exp_q1.size());
        check("l2_valid", lane2_valid, exp_q2.size() != 0);
        check("l2_data", lane2_data, exp_q2.size() != 0 ? exp_q2[0] : 20'h0);
        check("l2_count", lane2_count, exp_q2.size());
        acc  = in_valid && m_ready() && !rst;
        pop1 = lane1_ready && exp_q1.size() != 0 && !rst;
        pop2 = lane2_ready && exp_q2.size() != 0 && !rst;
        if (pop1) check("l1_recover", recover(lane1_data), itm_q1[0]);
        if (pop2) check("l2_recover", recover(lane2_data), itm_q2[0]);
        pkt = {m_seq, ~in_data, in_data ^ {4'h0, m_seq}};
        @(posedge clk);
        if (pop1) begin void'(exp_q1.pop_front()); void'(itm_q1.pop_front()); end
        if (pop2) begin void'(exp_q2.pop_front()); void'(itm_q2.pop_front()); end
        if (acc) begin
            if (m_next) begin exp_q2.push_back(pkt); itm_q2.push_back(in_data); end
            else        begin exp_q1.push_back(pkt); itm_q1.push_back(in_data); end
            m_next = ~m_next;
            m_seq  = m_seq + 4'd1;
        end
        #1;
    endtask

    // Asserts reset between edges and checks that state clears without a clock.
    task automatic async_reset();
        #2;
        rst = 1'b1;
        #1;
        check("ar_l1_valid", lane1_valid, 1'b0);
        check("ar_l2_valid", lane2_valid, 1'b0);
        check("ar_l1_count", lane1_count, 0);
        check("ar_l2_count", lane2_count, 0);
        check("ar_seq", seq, 0);
        check("ar_next", next_lane, 0);
        check("ar_in_ready", in_ready, 1'b1);
        exp_q1.delete(); exp_q2.delete(); itm_q1.delete(); itm_q2.delete();
        m_next = 1'b0;
        m_seq  = 4'h0;
        in_valid = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] items [10];
        logic [7:0] d17;
        int idx;
        logic will;

        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00;
        lane1_ready = 1'b0; lane2_ready = 1'b0;
        m_next = 1'b0; m_seq = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_l1_data", lane1_data, 20'h0);
        check("rst_l2_valid", lane2_valid, 1'b0);
        rst = 1'b0;
        tick();

        // First two packets: encoding anchors.
        in_valid = 1'b1; in_data = 8'hA5;
        tick();
        check("a5_packet", lane1_data, 20'h05AA5);
        check("a5_count", lane1_count, 1);
        check("a5_next", next_lane, 1'b1);
        check("a5_seq", seq, 4'h1);
        in_data = 8'h3C;
        tick();
        in_valid = 1'b0;
        check("3c_packet", lane2_data, 20'h1C33D);
        check("3c_seq", seq, 4'h2);
        check("3c_next", next_lane, 1'b0);
        lane1_ready = 1'b1;
        tick();
        lane1_ready = 1'b0;
        check("l1_drop", lane1_valid, 1'b0);
        lane2_ready = 1'b1;
        tick();
        lane2_ready = 1'b0;

        // Back-to-back burst into stalled lanes: only 2*depth fit.
        for (int i = 0; i < 10; i++) items[i] = 8'($urandom);
        idx = 0;
        for (int c = 0; c < 12; c++) begin
            in_valid = 1'b1; in_data = items[idx];
            will = m_ready();
            tick();
            if (will) idx++;
        end
        check("burst_accepted", idx, 8);
        check("burst_l1_full", lane1_count, 4);
        check("burst_l2_full", lane2_count, 4);
        check("burst_ready_lo", in_ready, 1'b0);
        lane1_ready = 1'b1;
        tick();
        lane1_ready = 1'b0;
        check("ready_after_pop", in_ready, 1'b1);
        will = m_ready();
        tick();
        if (will) idx++;
        check("item9_taken", idx, 9);
        check("item9_lane1", lane1_count, 4);

        // Imbalance: lane 1 has room, but next item belongs to lane 2.
        in_data = items[9];
        lane1_ready = 1'b1;
        repeat (3) tick();
        lane1_ready = 1'b0;
        repeat (3) tick();
        check("imb_l1_count", lane1_count, 1);
        check("imb_ready_lo", in_ready, 1'b0);
        lane2_ready = 1'b1;
        tick();
        lane2_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        check("imb_l1_untouched", lane1_count, 1);
        check("imb_l2_refill", lane2_count, 4);

        lane1_ready = 1'b1; lane2_ready = 1'b1;
        repeat (10) tick();
        lane1_ready = 1'b0; lane2_ready = 1'b0;

        // Async reset with lanes at 3/2.
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_data = 8'($urandom);
            tick();
        end
        in_valid = 1'b0;
        check("pre_rst_l1", lane1_count, 3);
        check("pre_rst_l2", lane2_count, 2);
        async_reset();
        in_valid = 1'b1; in_data = 8'hFF;
        tick();
        in_valid = 1'b0;
        check("ff_packet", lane1_data, 20'h000FF);
        lane1_ready = 1'b1; lane2_ready = 1'b1;
        repeat (2) tick();
        lane1_ready = 1'b0; lane2_ready = 1'b0;

        // Sequence wrap with free-flowing lanes.
        async_reset();
        lane1_ready = 1'b1; lane2_ready = 1'b1;
        d17 = 8'h00;
        for (int i = 0; i < 17; i++) begin
            in_valid = 1'b1; in_data = 8'($urandom);
            d17 = in_data;
            tick();
        end
        in_valid = 1'b0;
        check("wrap_l1_valid", lane1_valid, 1'b1);
        check("wrap_packet", lane1_data, {4'h0, ~d17, d17});
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
